// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module   : mem_arbiter_pkg
// Summary  : Shared widths and FSM state encodings for the memory arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    localparam int REG_DATA_WIDTH = 32;
    localparam int PC_WIDTH       = 32;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_GRANT_IF = 2'd1,
        ARB_GRANT_D  = 2'd2,
        ARB_RESP     = 2'd3
    } arb_state_t;

    function automatic logic [REG_DATA_WIDTH-1:0] zext_pc(input logic [PC_WIDTH-1:0] pc);
        return REG_DATA_WIDTH'(pc);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_arb_counter.sv
// ============================================================================
// Module   : arb_counter
// Summary  : Saturating up-counter with clear (priority), increment and limit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module arb_counter
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_at_limit
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count < i_limit)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_at_limit = (r_count >= i_limit);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Summary  : Shares one variable-latency memory between fetch and data ports.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT      = 16,
    parameter int D_STREAK_MAX = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_req_i,
    input  logic [PC_WIDTH-1:0]       if_addr_i,
    output logic [REG_DATA_WIDTH-1:0] if_rdata_o,
    output logic                      if_valid_o,
    input  logic                      d_req_i,
    input  logic                      d_we_i,
    input  logic [REG_DATA_WIDTH-1:0] d_addr_i,
    input  logic [REG_DATA_WIDTH-1:0] d_wdata_i,
    output logic [REG_DATA_WIDTH-1:0] d_rdata_o,
    output logic                      d_valid_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [REG_DATA_WIDTH-1:0] mem_addr_o,
    output logic [REG_DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [REG_DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                      mem_ready_i,
    output logic                      stall_o,
    output logic                      err_o
);

    localparam int STREAK_W = 3;
    localparam int WAIT_W   = $clog2(TIMEOUT + 1);

    arb_state_t                r_state;
    logic                      r_mem_req;
    logic                      r_mem_we;
    logic [REG_DATA_WIDTH-1:0] r_mem_addr;
    logic [REG_DATA_WIDTH-1:0] r_mem_wdata;
    logic [REG_DATA_WIDTH-1:0] r_if_rdata;
    logic [REG_DATA_WIDTH-1:0] r_d_rdata;
    logic                      r_if_valid;
    logic                      r_d_valid;
    logic                      r_err;

    logic w_grant_d;
    logic w_grant_if;
    logic w_in_grant;
    logic w_expire;
    logic w_done;
    logic w_streak_sat;
    logic w_wait_last;
    logic w_streak_clr;

    always_comb begin
        w_grant_d    = (r_state == ARB_IDLE) && d_req_i && (!if_req_i || !w_streak_sat);
        w_grant_if   = (r_state == ARB_IDLE) && if_req_i && !w_grant_d;
        w_in_grant   = (r_state == ARB_GRANT_IF) || (r_state == ARB_GRANT_D);
        w_expire     = w_in_grant && !mem_ready_i && w_wait_last;
        w_done       = w_in_grant && (mem_ready_i || w_expire);
        w_streak_clr = w_grant_if || (w_grant_d && !if_req_i);
    end

    arb_counter #(
        .WIDTH (STREAK_W)
    ) u_streak (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_streak_clr),
        .i_inc      (w_grant_d),
        .i_limit    (STREAK_W'(D_STREAK_MAX)),
        .o_at_limit (w_streak_sat)
    );

    // Limit is TIMEOUT-1: in the last allowed wait cycle the count would
    // reach TIMEOUT on this edge, so the abort is taken right here.
    arb_counter #(
        .WIDTH (WAIT_W)
    ) u_wait (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_grant_d || w_grant_if),
        .i_inc      (w_in_grant),
        .i_limit    (WAIT_W'(TIMEOUT - 1)),
        .o_at_limit (w_wait_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ARB_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_valid  <= 1'b0;
            r_d_valid   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant_d) begin
                        r_state     <= ARB_GRANT_D;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= d_we_i;
                        r_mem_addr  <= d_addr_i;
                        r_mem_wdata <= d_wdata_i;
                    end else if (w_grant_if) begin
                        r_state     <= ARB_GRANT_IF;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= zext_pc(if_addr_i);
                        r_mem_wdata <= '0;
                    end
                end
                ARB_GRANT_IF, ARB_GRANT_D: begin
                    if (w_done) begin
                        r_state     <= ARB_RESP;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                        if (w_expire) begin
                            r_err <= 1'b1;
                        end
                        if (r_state == ARB_GRANT_IF) begin
                            r_if_valid <= 1'b1;
                            r_if_rdata <= w_expire ? '0 : mem_rdata_i;
                        end else begin
                            r_d_valid <= 1'b1;
                            r_d_rdata <= w_expire ? '0 : mem_rdata_i;
                        end
                    end
                end
                ARB_RESP: begin
                    r_state <= ARB_IDLE;
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign if_rdata_o  = r_if_rdata;
    assign if_valid_o  = r_if_valid;
    assign d_rdata_o   = r_d_rdata;
    assign d_valid_o   = r_d_valid;
    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign err_o       = r_err;

    // Stall is gated by reset so every output reads 0 while reset is held.
    assign stall_o = rst && ((if_req_i && !r_if_valid) || (d_req_i && !r_d_valid));

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Summary  : Directed, table-driven self-checking bench for mem_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_valid_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [31:0] d_rdata_o;
    logic        d_valid_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ready_i;
    logic        stall_o;
    logic        err_o;

    int n_cmp;
    int n_bad;

    mem_arbiter #(
        .TIMEOUT      (16),
        .D_STREAK_MAX (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_rdata_o  (if_rdata_o),
        .if_valid_o  (if_valid_o),
        .d_req_i     (d_req_i),
        .d_we_i      (d_we_i),
        .d_addr_i    (d_addr_i),
        .d_wdata_i   (d_wdata_i),
        .d_rdata_o   (d_rdata_o),
        .d_valid_o   (d_valid_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ready_i (mem_ready_i),
        .stall_o     (stall_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic        chk_rdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        if (v.is_d) begin
            d_req_i   = 1'b1;
            d_we_i    = v.we;
            d_addr_i  = v.addr;
            d_wdata_i = v.wdata;
            if_addr_i = 32'hBAD0_0000;
        end else begin
            if_req_i  = 1'b1;
            if_addr_i = v.addr;
            d_we_i    = 1'b1;
            d_addr_i  = 32'hBAD0_0004;
            d_wdata_i = 32'hBAD0_0008;
        end
        #1;
        chk("stall_c0", stall_o, 1);
        chk("memreq_c0", mem_req_o, 0);
        for (int c = 1; c <= v.delay; c++) begin
            tick();
            chk("memreq_wait", mem_req_o, 1);
            chk("memwe_wait", mem_we_o, v.exp_we);
            chk("memaddr_wait", mem_addr_o, v.exp_addr);
            if (v.exp_we) chk("memwdata_wait", mem_wdata_o, v.exp_wdata);
            chk("valid_wait", v.is_d ? d_valid_o : if_valid_o, 0);
            chk("stall_wait", stall_o, 1);
            if (c == v.delay) begin
                mem_ready_i = 1'b1;
                mem_rdata_i = v.rdata;
            end
        end
        tick();
        mem_ready_i = 1'b0;
        mem_rdata_i = 32'h5A5A_5A5A;
        chk("memreq_resp", mem_req_o, 0);
        chk("valid_resp", v.is_d ? d_valid_o : if_valid_o, 1);
        chk("other_valid_resp", v.is_d ? if_valid_o : d_valid_o, 0);
        if (v.chk_rdata) chk("rdata_resp", v.is_d ? d_rdata_o : if_rdata_o, v.exp_rdata);
        chk("stall_resp", stall_o, 0);
        if_req_i = 1'b0;
        d_req_i  = 1'b0;
        tick();
        chk("valid_after", v.is_d ? d_valid_o : if_valid_o, 0);
    endtask

    initial begin
        logic exp_order[10];
        int   cnt;
        logic got_grant;

        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        if_req_i = 1'b0; if_addr_i = '0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
        mem_rdata_i = '0; mem_ready_i = 1'b0;

        //            is_d  we    addr           wdata          rdata          dly exp_we exp_addr       exp_wdata      chk  exp_rdata
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         32'h0000_0013, 1, 1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'h0000_0013};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0,         3, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_2004, 32'h0,         32'hCAFE_F00D, 2, 1'b0, 32'h0000_2004, 32'h0,         1'b1, 32'hCAFE_F00D};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,         32'h00A0_0093, 4, 1'b0, 32'h0000_0104, 32'h0,         1'b1, 32'h00A0_0093};
        vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h1234_5678, 1, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h1234_5678};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0010, 32'h0000_00FF, 32'h0,         1, 1'b1, 32'h0000_0010, 32'h0000_00FF, 1'b0, 32'h0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_memreq", mem_req_o, 0);
        chk("rst_memwe", mem_we_o, 0);
        chk("rst_memaddr", mem_addr_o, 0);
        chk("rst_ifvalid", if_valid_o, 0);
        chk("rst_dvalid", d_valid_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_stall", stall_o, 0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Both requesters held: data wins until four in a row, then fetch.
        do_reset();
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        if_req_i = 1'b1; if_addr_i = 32'h0000_0100;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_2000;
        for (int n = 0; n < 10; n++) begin
            cnt = 0;
            got_grant = 1'b0;
            while (!got_grant && cnt < 8) begin
                tick();
                cnt++;
                got_grant = mem_req_o;
            end
            chk("order_grant_seen", got_grant, 1);
            chk("order_owner_is_d", (mem_addr_o == 32'h0000_2000) ? 1 : 0, exp_order[n]);
            mem_ready_i = 1'b1;
            tick();
            mem_ready_i = 1'b0;
        end
        if_req_i = 1'b0;
        d_req_i  = 1'b0;
        tick();
        tick();

        // Memory never answers: abort after 16 request cycles.
        chk("pre_to_err", err_o, 0);
        mem_rdata_i = 32'hFFFF_FFFF;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_3000;
        tick();
        cnt = 0;
        while (mem_req_o && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("to_req_cycles", cnt, 16);
        chk("to_dvalid", d_valid_o, 1);
        chk("to_rdata_zero", d_rdata_o, 0);
        chk("to_err", err_o, 1);
        d_req_i = 1'b0;
        tick();
        chk("to_dvalid_after", d_valid_o, 0);
        chk("to_err_sticky", err_o, 1);
        run_vec(vecs[0]);
        chk("to_err_sticky2", err_o, 1);

        // Asynchronous reset during a data grant.
        d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h0000_4000; d_wdata_i = 32'h0000_0011;
        tick();
        chk("ar_memreq_before", mem_req_o, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_memreq", mem_req_o, 0);
        chk("ar_memwe", mem_we_o, 0);
        chk("ar_memaddr", mem_addr_o, 0);
        chk("ar_memwdata", mem_wdata_o, 0);
        chk("ar_err", err_o, 0);
        chk("ar_stall", stall_o, 0);
        chk("ar_dvalid", d_valid_o, 0);
        d_req_i = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ar_no_valid", d_valid_o | if_valid_o, 0);
            chk("ar_idle_memreq", mem_req_o, 0);
        end
        run_vec(vecs[3]);

        // Stray ready while idle must be ignored.
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'h7777_7777;
        tick();
        chk("stray_valid", if_valid_o | d_valid_o, 0);
        chk("stray_memreq", mem_req_o, 0);
        mem_ready_i = 1'b0;
        tick();
        chk("stray_valid2", if_valid_o | d_valid_o, 0);
        run_vec(vecs[2]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencing controller that shares one single-port, variable-latency memory between the instruction-fetch requester and the data requester driven by the memory-access stage. Sits between the core's fetch and memory-access logic and the external memory. It grants one requester per transaction, holds the memory request stable until the memory acknowledges, and returns read data with a one-cycle valid pulse. It drives a pipeline stall while any requester is waiting.

## Interface
Parameters:
- `TIMEOUT`, 16: max cycles a transaction waits for `mem_ready_i` before abort.
- `D_STREAK_MAX`, 4: consecutive data grants after which a pending fetch is granted first.

Ports (`REG_DATA_WIDTH`/`PC_WIDTH` from `riscv_def.v`):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `if_req_i` in 1: fetch request, level, held until `if_valid_o`.
- `if_addr_i` in `PC_WIDTH`: fetch address.
- `if_rdata_o` out `REG_DATA_WIDTH`: fetched instruction.
- `if_valid_o` out 1: one-cycle pulse, `if_rdata_o` valid.
- `d_req_i` in 1: data request (data memory enable), level, held until `d_valid_o`.
- `d_we_i` in 1: 1 = store, 0 = load.
- `d_addr_i` in `REG_DATA_WIDTH`: data address.
- `d_wdata_i` in `REG_DATA_WIDTH`: store data.
- `d_rdata_o` out `REG_DATA_WIDTH`: load data.
- `d_valid_o` out 1: one-cycle pulse, data transaction complete (load or store).
- `mem_req_o` out 1: memory request.
- `mem_we_o` out 1: memory write enable.
- `mem_addr_o` out `REG_DATA_WIDTH`: memory address (fetch address zero-extended).
- `mem_wdata_o` out `REG_DATA_WIDTH`: memory write data.
- `mem_rdata_i` in `REG_DATA_WIDTH`: memory read data, valid with `mem_ready_i`.
- `mem_ready_i` in 1: memory completion, one cycle.
- `stall_o` out 1: pipeline hold.
- `err_o` out 1: sticky timeout flag.

## Operation
- FSM states: IDLE, GRANT_IF, GRANT_D, RESP.
- IDLE: if `d_req_i` and (not `if_req_i` or streak < `D_STREAK_MAX`) -> GRANT_D. Else if `if_req_i` -> GRANT_IF. Else stay.
- On grant: latch address, write enable and wdata into registers. Drive `mem_req_o`=1 from these registers, never from live inputs.
- GRANT_x: hold `mem_*` outputs stable. On `mem_ready_i`, capture `mem_rdata_i`, drop `mem_req_o`, go to RESP.
- RESP: pulse the owner's `*_valid_o` for exactly one cycle, then go to IDLE.
- Streak counter (3 bits, saturating at `D_STREAK_MAX`): increments on each data grant. Clears on each fetch grant and whenever fetch is not requesting at a data grant.
- Wait counter: clears on grant and increments each GRANT_x cycle. If it reaches `TIMEOUT` without `mem_ready_i`, then: set `err_o`, drop `mem_req_o`, pulse the owner's valid with rdata = 0, and return to IDLE via RESP.
- `stall_o` = (`if_req_i` or `d_req_i`) and not the corresponding valid pulse this cycle.
- A requester dropping its request mid-transaction is illegal. The transaction still completes and the valid pulse is still emitted.

## Timing
- Reset values: state IDLE; all outputs 0; counters 0; `err_o` 0; latched registers 0.
- Reset mid-transaction: asynchronous abort, outputs 0 immediately, no valid pulse.
- Minimum latency, request to valid: request at cycle 0. Grant and `mem_req_o` rise at edge 1. With `mem_ready_i` in cycle 1, capture at edge 2 and the valid pulse is in cycle 2. Total 2 cycles plus memory wait.
- `mem_ready_i` while not in GRANT_x is ignored.
- Simultaneous `if_req_i` and `d_req_i` in IDLE: data wins unless the streak is saturated.
- Back-to-back: minimum 1 IDLE cycle between transactions. Throughput is at most 1 transaction per 3 cycles.
- `err_o` clears only on reset.

## Structure
- Widths come from `riscv_def.v`. Add the state encodings `ARB_IDLE`, `ARB_GRANT_IF`, `ARB_GRANT_D` and `ARB_RESP` there as `define constants.
- One sub-module, `arb_counter`: a saturating counter with clear, increment and limit inputs. It is instantiated twice, once for streak and once for wait. Everything else stays in one module.

## Test plan
- Reset, then `if_req_i`=1 with `if_addr_i`=0x100 and `mem_ready_i` at the first request cycle. Expect `mem_addr_o`=0x100 for 1 cycle and an `if_valid_o` pulse 2 cycles after the request with `if_rdata_o`=`mem_rdata_i`.
- Store with `d_addr_i`=0x2000 and `d_wdata_i`=0xDEADBEEF, with a 3-cycle memory delay. Expect `mem_we_o`=1 and address/data stable for 3 cycles, then a `d_valid_o` pulse, with `stall_o` high throughout.
- Both requests held continuously. Expect the grant order D,D,D,D,IF,D,D,D,D,IF.
- `mem_ready_i` never asserted. Expect `mem_req_o` to drop after 16 cycles, `err_o`=1 (sticky), and a valid pulse with rdata 0.
- Assert `rst`=0 mid-GRANT_D. Expect all outputs 0 asynchronously and no valid pulse; after release, state is IDLE and a new fetch completes normally.
- Stray `mem_ready_i` in IDLE. Expect no valid pulse and no state change.
